// File: rtl/trap_controller.sv
// Machine-mode trap sequencer: serialises mepc/mcause/mtval writes over one CSR port,
// reads mtvec (trap) or mepc (MRET) and issues a one-cycle PC redirect.
module trap_controller #(
   parameter int unsigned XLEN        = 32,
   parameter logic [11:0] ADDR_MTVEC  = 12'h305,
   parameter logic [11:0] ADDR_MEPC   = 12'h341,
   parameter logic [11:0] ADDR_MCAUSE = 12'h342,
   parameter logic [11:0] ADDR_MTVAL  = 12'h343
) (
   input  logic            clk,
   input  logic            reset_n,
   input  logic            trapped,
   input  logic [1:0]      trap_status,
   input  logic [XLEN-1:0] pc,
   input  logic [XLEN-1:0] fault_target,
   input  logic [XLEN-1:0] csr_read_data,
   output logic [11:0]     csr_read_address,
   output logic            csr_write_enable,
   output logic [11:0]     csr_write_address,
   output logic [XLEN-1:0] csr_write_data,
   output logic            trap_stall,
   output logic            pc_redirect,
   output logic [XLEN-1:0] redirect_target
);

   typedef enum logic [2:0] {
      IDLE, W_MEPC, W_MCAUSE, W_MTVAL, R_MTVEC, R_MEPC, REDIRECT
   } state_t;

   localparam logic [XLEN-1:0] ALIGN_MASK = {{(XLEN-2){1'b1}}, 2'b00};

   state_t          state;
   logic [XLEN-1:0] pc_l;
   logic [XLEN-1:0] fault_target_l;
   logic [1:0]      status_l;

   function automatic logic [XLEN-1:0] mcause_code(input logic [1:0] s);
      case (s)
         2'b00:   mcause_code = XLEN'(11);
         2'b01:   mcause_code = XLEN'(3);
         default: mcause_code = '0;
      endcase
   endfunction

   function automatic logic [XLEN-1:0] mtval_value(input logic [1:0] s,
                                                   input logic [XLEN-1:0] p,
                                                   input logic [XLEN-1:0] t);
      case (s)
         2'b01:   mtval_value = p;
         2'b10:   mtval_value = t;
         default: mtval_value = '0;
      endcase
   endfunction

   // Outputs are registered: each state's strobes/addresses are loaded on the edge that enters it.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state             <= IDLE;
         pc_l              <= '0;
         fault_target_l    <= '0;
         status_l          <= '0;
         csr_read_address  <= '0;
         csr_write_enable  <= 1'b0;
         csr_write_address <= '0;
         csr_write_data    <= '0;
         pc_redirect       <= 1'b0;
         redirect_target   <= '0;
      end else begin
         csr_write_enable  <= 1'b0;
         csr_write_address <= '0;
         csr_write_data    <= '0;
         csr_read_address  <= '0;
         pc_redirect       <= 1'b0;
         case (state)
            IDLE: begin
               if (trapped) begin
                  pc_l           <= pc;
                  fault_target_l <= fault_target;
                  status_l       <= trap_status;
                  if (trap_status == 2'b11) begin
                     state            <= R_MEPC;
                     csr_read_address <= ADDR_MEPC;
                  end else begin
                     state             <= W_MEPC;
                     csr_write_enable  <= 1'b1;
                     csr_write_address <= ADDR_MEPC;
                     csr_write_data    <= pc & ALIGN_MASK;
                  end
               end
            end
            W_MEPC: begin
               state             <= W_MCAUSE;
               csr_write_enable  <= 1'b1;
               csr_write_address <= ADDR_MCAUSE;
               csr_write_data    <= mcause_code(status_l);
            end
            W_MCAUSE: begin
               state             <= W_MTVAL;
               csr_write_enable  <= 1'b1;
               csr_write_address <= ADDR_MTVAL;
               csr_write_data    <= mtval_value(status_l, pc_l, fault_target_l);
            end
            W_MTVAL: begin
               state            <= R_MTVEC;
               csr_read_address <= ADDR_MTVEC;
            end
            R_MTVEC, R_MEPC: begin
               state           <= REDIRECT;
               pc_redirect     <= 1'b1;
               redirect_target <= csr_read_data & ALIGN_MASK;
            end
            REDIRECT: state <= IDLE;
            default:  state <= IDLE;
         endcase
      end
   end

   assign trap_stall = (state == IDLE) ? trapped : 1'b1;

endmodule

// File: tb/tb_trap_controller.sv
// Randomised bench for trap_controller with a CSR file and a cycle-schedule reference model.
module tb_trap_controller;

   logic        clk = 1'b0;
   logic        reset_n;
   logic        trapped;
   logic [1:0]  trap_status;
   logic [31:0] pc;
   logic [31:0] fault_target;
   logic [31:0] csr_read_data;
   logic [11:0] csr_read_address;
   logic        csr_write_enable;
   logic [11:0] csr_write_address;
   logic [31:0] csr_write_data;
   logic        trap_stall;
   logic        pc_redirect;
   logic [31:0] redirect_target;

   always #5 clk = ~clk;

   trap_controller #(.XLEN(32)) dut (
      .clk(clk), .reset_n(reset_n), .trapped(trapped), .trap_status(trap_status),
      .pc(pc), .fault_target(fault_target), .csr_read_data(csr_read_data),
      .csr_read_address(csr_read_address), .csr_write_enable(csr_write_enable),
      .csr_write_address(csr_write_address), .csr_write_data(csr_write_data),
      .trap_stall(trap_stall), .pc_redirect(pc_redirect), .redirect_target(redirect_target)
   );

   // CSR file seen by the DUT; the bench preloads it through a backdoor port
   logic [31:0] csr_mtvec, csr_mepc, csr_mcause, csr_mtval;
   logic        bd_en = 1'b0;
   logic [11:0] bd_addr = '0;
   logic [31:0] bd_data = '0;
   logic        w_en;
   logic [11:0] w_addr;
   logic [31:0] w_data;

   always_comb begin
      w_en   = bd_en | csr_write_enable;
      w_addr = bd_en ? bd_addr : csr_write_address;
      w_data = bd_en ? bd_data : csr_write_data;
   end

   always @(posedge clk) begin
      if (w_en) begin
         case (w_addr)
            12'h305: csr_mtvec  <= w_data;
            12'h341: csr_mepc   <= w_data;
            12'h342: csr_mcause <= w_data;
            12'h343: csr_mtval  <= w_data;
            default: ;
         endcase
      end
   end

   always_comb begin
      case (csr_read_address)
         12'h305: csr_read_data = csr_mtvec;
         12'h341: csr_read_data = csr_mepc;
         12'h342: csr_read_data = csr_mcause;
         12'h343: csr_read_data = csr_mtval;
         default: csr_read_data = '0;
      endcase
   end

   // reference model state
   logic [31:0] m_mtvec, m_mepc, m_mcause, m_mtval, exp_target;
   int n_checks = 0;
   int n_pass   = 0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %h expected %h", tag, got, exp);
   endtask

   task automatic check_idle();
      check("idle_stall", 32'(trap_stall), 32'(trapped));
      check("idle_we", 32'(csr_write_enable), 0);
      check("idle_redirect", 32'(pc_redirect), 0);
      check("idle_raddr", 32'(csr_read_address), 0);
      check("idle_target", redirect_target, exp_target);
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) begin
         check_idle();
         @(negedge clk);
      end
   endtask

   task automatic set_csr(input logic [11:0] a, input logic [31:0] d);
      bd_en = 1'b1; bd_addr = a; bd_data = d;
      case (a)
         12'h305: m_mtvec  = d;
         12'h341: m_mepc   = d;
         12'h342: m_mcause = d;
         default: m_mtval  = d;
      endcase
      check_idle();
      @(negedge clk);
      bd_en = 1'b0;
   endtask

   // Called at a negedge with the DUT idle; returns at the negedge of the first idle cycle after REDIRECT.
   task automatic run_trap(input logic [1:0] kind, input logic [31:0] tpc,
                           input logic [31:0] tft, input bit hold);
      int          len;
      logic [31:0] cause, tval, e_wd;
      logic [11:0] e_wa, e_ra;
      logic        e_we, e_red;
      trapped = 1'b1; trap_status = kind; pc = tpc; fault_target = tft;
      #1 check("accept_stall", 32'(trap_stall), 1);
      len   = (kind == 2'b11) ? 2 : 5;
      cause = (kind == 2'b00) ? 32'd11 : (kind == 2'b01) ? 32'd3 : 32'd0;
      tval  = (kind == 2'b00) ? 32'd0 : (kind == 2'b01) ? tpc : tft;
      for (int k = 1; k <= len + 1; k++) begin
         @(negedge clk);
         e_we = 1'b0; e_wa = '0; e_wd = '0; e_ra = '0; e_red = 1'b0;
         if (kind != 2'b11) begin
            case (k)
               1: begin e_we = 1'b1; e_wa = 12'h341; e_wd = tpc & 32'hFFFF_FFFC; end
               2: begin e_we = 1'b1; e_wa = 12'h342; e_wd = cause; end
               3: begin e_we = 1'b1; e_wa = 12'h343; e_wd = tval; end
               4: e_ra = 12'h305;
               5: begin e_red = 1'b1; exp_target = m_mtvec & 32'hFFFF_FFFC; end
               default: ;
            endcase
         end else begin
            case (k)
               1: e_ra = 12'h341;
               2: begin e_red = 1'b1; exp_target = m_mepc & 32'hFFFF_FFFC; end
               default: ;
            endcase
         end
         check("stall", 32'(trap_stall), (k <= len) ? 32'd1 : 32'(trapped));
         check("we", 32'(csr_write_enable), 32'(e_we));
         check("raddr", 32'(csr_read_address), 32'(e_ra));
         check("redirect", 32'(pc_redirect), 32'(e_red));
         check("target", redirect_target, exp_target);
         if (e_we) begin
            check("waddr", 32'(csr_write_address), 32'(e_wa));
            check("wdata", csr_write_data, e_wd);
            case (e_wa)
               12'h341: m_mepc   = e_wd;
               12'h342: m_mcause = e_wd;
               default: m_mtval  = e_wd;
            endcase
         end
         if (k <= len) begin
            if (!hold) trapped = 1'b0;
            else trap_status = 2'($urandom);
            pc = $urandom; fault_target = $urandom;
         end
      end
   endtask

   task automatic check_reset_outputs(input string tag);
      check({tag, "_we"}, 32'(csr_write_enable), 0);
      check({tag, "_waddr"}, 32'(csr_write_address), 0);
      check({tag, "_wdata"}, csr_write_data, 0);
      check({tag, "_raddr"}, 32'(csr_read_address), 0);
      check({tag, "_redirect"}, 32'(pc_redirect), 0);
      check({tag, "_target"}, redirect_target, 0);
      check({tag, "_stall"}, 32'(trap_stall), 0);
   endtask

   initial begin
      bit prev_hold;
      logic [1:0] kind;
      bit hold;
      reset_n = 1'b0; trapped = 1'b0; trap_status = '0; pc = '0; fault_target = '0;
      exp_target = '0;
      #12 check_reset_outputs("reset");
      @(negedge clk);
      reset_n = 1'b1;
      idle(2);
      set_csr(12'h305, 32'h0); set_csr(12'h341, 32'h0);
      set_csr(12'h342, 32'h0); set_csr(12'h343, 32'h0);

      // ECALL, misaligned, MRET, held EBREAK followed by back-to-back EBREAK
      set_csr(12'h305, 32'h200);
      run_trap(2'b00, 32'h100, 32'h0, 1'b0);
      set_csr(12'h305, 32'h203);
      run_trap(2'b10, 32'h80, 32'hF1, 1'b0);
      set_csr(12'h341, 32'h104);
      run_trap(2'b11, 32'h500, 32'h0, 1'b0);
      run_trap(2'b01, 32'h246, 32'h9, 1'b1);
      run_trap(2'b01, 32'h3F8, 32'h0, 1'b0);
      idle(1);

      // reset in W_MCAUSE: strobe drops at once, mcause never written, no redirect
      trapped = 1'b1; trap_status = 2'b00; pc = 32'h777; fault_target = '0;
      @(negedge clk);
      trapped = 1'b0;
      m_mepc = 32'h774;
      @(negedge clk);
      check("abort_we_before", 32'(csr_write_enable), 1);
      reset_n = 1'b0;
      #1 check_reset_outputs("abort");
      exp_target = '0;
      @(negedge clk);
      reset_n = 1'b1;
      idle(6);

      prev_hold = 1'b0;
      for (int i = 0; i < 40; i++) begin
         kind = 2'($urandom_range(0, 3));
         hold = (i != 39) && ($urandom_range(0, 3) == 0);
         if (!prev_hold) begin
            idle($urandom_range(0, 2));
            if ($urandom_range(0, 1) == 1) set_csr(12'h305, $urandom);
            if ($urandom_range(0, 2) == 0) set_csr(12'h341, $urandom);
         end
         run_trap(kind, $urandom, $urandom, hold);
         prev_hold = hold;
      end
      trapped = 1'b0;
      idle(2);
      check("csr_mtvec", csr_mtvec, m_mtvec);
      check("csr_mepc", csr_mepc, m_mepc);
      check("csr_mcause", csr_mcause, m_mcause);
      check("csr_mtval", csr_mtval, m_mtval);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
